// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory side of the core.
//   BUS_WIDTH   : byte-address / instruction word width (also used by
//                 instruction_memory).
//   INSTR_BYTES : bytes per instruction word; the loader address stride.
//   loader_state_t : state encoding of the instruction-memory loader.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int BUS_WIDTH   = 16;
    localparam int INSTR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_LO = 3'd1,
        ST_GET_HI = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Write-side companion to the instruction memory. Takes a byte stream over a
// valid/ready handshake, packs byte pairs (low byte first) into 16-bit words
// and writes them to consecutive even byte addresses starting at base_addr.
// busy holds the CPU off the fetch path while a load is in progress.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   start        one-cycle load request, only honoured in IDLE
//   abort        cancels a load in progress; wins over start
//   base_addr    byte address of the first word (must be even)
//   word_count   number of words to load (0 is legal)
//   in_valid     stream byte valid
//   in_data      stream byte
//   in_ready     loader consumes a byte this cycle
//   mem_wr_en    one-cycle instruction memory write strobe
//   mem_wr_addr  byte address of the write (held between writes)
//   mem_wr_data  assembled instruction word (held between writes)
//   busy         load in progress (any state except IDLE)
//   done         one-cycle pulse after the last word is written
//   error        one-cycle pulse when start is rejected for an odd base_addr
// -----------------------------------------------------------------------------
module imem_loader
    import mips_pkg::*;
#(
    parameter int BUS_WIDTH   = mips_pkg::BUS_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BUS_WIDTH-1:0]   base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_wr_en,
    output logic [BUS_WIDTH-1:0]   mem_wr_addr,
    output logic [BUS_WIDTH-1:0]   mem_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    loader_state_t          r_state;
    loader_state_t          w_state_nxt;

    logic [BUS_WIDTH-1:0]   r_addr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [7:0]             r_lo;
    logic [BUS_WIDTH-1:0]   r_wr_addr;
    logic [BUS_WIDTH-1:0]   r_wr_data;
    logic                   r_error;

    logic                   w_in_ready;
    logic                   w_wr_en;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_lo_take;
    logic                   w_hi_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_wr_en     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_lo_take   = 1'b0;
        w_hi_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                // abort in IDLE suppresses the request entirely, error included
                if (start && !abort) begin
                    if (base_addr[0]) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (word_count == '0) ? ST_DONE : ST_GET_LO;
                    end
                end
            end
            ST_GET_LO: begin
                w_in_ready = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (in_valid) begin
                    w_lo_take   = 1'b1;
                    w_state_nxt = ST_GET_HI;
                end
            end
            ST_GET_HI: begin
                w_in_ready = 1'b1;
                // a byte handshaken together with abort is dropped along with
                // the pending low byte
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (in_valid) begin
                    w_hi_take   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // the strobe is already out this cycle, so abort cannot cancel it
                w_wr_en = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == COUNT_WIDTH'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_GET_LO;
                end
            end
            ST_DONE: begin
                w_done      = !abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_lo      <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_error   <= 1'b0;
        end else begin
            r_error <= w_reject;
            if (w_accept) begin
                r_addr  <= base_addr;
                r_count <= word_count;
            end
            if (w_lo_take) begin
                r_lo <= in_data;
            end
            if (w_hi_take) begin
                r_wr_addr <= r_addr;
                r_wr_data <= BUS_WIDTH'({in_data, r_lo});
            end
            // address wraps naturally at 2^BUS_WIDTH
            if (r_state == ST_WRITE) begin
                r_addr  <= r_addr + BUS_WIDTH'(INSTR_BYTES);
                r_count <= r_count - COUNT_WIDTH'(1);
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign mem_wr_en   = w_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
    assign busy        = w_busy;
    assign done        = w_done;
    assign error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec;
    int n_err;

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] cnt);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        tick();
        start = 1'b0;
    endtask

    // present lo then hi with in_valid high; returns at the WRITE cycle
    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
        in_valid = 1'b1;
        in_data  = lo;
        tick();
        in_data = hi;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        // reset state
        tick();
        tick();
        chk("rst_busy",    {15'd0, busy},      16'h0000);
        chk("rst_ready",   {15'd0, in_ready},  16'h0000);
        chk("rst_wren",    {15'd0, mem_wr_en}, 16'h0000);
        chk("rst_addr",    mem_wr_addr,        16'h0000);
        chk("rst_data",    mem_wr_data,        16'h0000);
        chk("rst_done",    {15'd0, done},      16'h0000);
        chk("rst_error",   {15'd0, error},     16'h0000);
        rst = 1'b1;
        tick();
        chk("idle_busy",   {15'd0, busy},      16'h0000);

        // basic load, in_valid held high throughout
        do_start(16'h0010, 16'd2);
        chk("b_busy",      {15'd0, busy},      16'h0001);
        chk("b_ready_lo",  {15'd0, in_ready},  16'h0001);
        in_valid = 1'b1;
        in_data  = 8'h34;
        tick();
        chk("b_ready_hi",  {15'd0, in_ready},  16'h0001);
        chk("b_wren_hi",   {15'd0, mem_wr_en}, 16'h0000);
        in_data = 8'h12;
        tick();
        chk("b_wren1",     {15'd0, mem_wr_en}, 16'h0001);
        chk("b_addr1",     mem_wr_addr,        16'h0010);
        chk("b_data1",     mem_wr_data,        16'h1234);
        chk("b_ready_wr",  {15'd0, in_ready},  16'h0000);
        in_data = 8'h78;
        tick();
        chk("b_wren1_end", {15'd0, mem_wr_en}, 16'h0000);
        chk("b_ready_lo2", {15'd0, in_ready},  16'h0001);
        tick();
        in_data = 8'h56;
        tick();
        chk("b_wren2",     {15'd0, mem_wr_en}, 16'h0001);
        chk("b_addr2",     mem_wr_addr,        16'h0012);
        chk("b_data2",     mem_wr_data,        16'h5678);
        in_valid = 1'b0;
        tick();
        chk("b_done",      {15'd0, done},      16'h0001);
        chk("b_wren_off",  {15'd0, mem_wr_en}, 16'h0000);
        chk("b_busy_done", {15'd0, busy},      16'h0001);
        chk("b_hold_addr", mem_wr_addr,        16'h0012);
        chk("b_hold_data", mem_wr_data,        16'h5678);
        tick();
        chk("b_done_end",  {15'd0, done},      16'h0000);
        chk("b_busy_end",  {15'd0, busy},      16'h0000);

        // throttled source: valid 1/0 alternating
        do_start(16'h0100, 16'd1);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        tick();
        chk("t_wait_wren", {15'd0, mem_wr_en}, 16'h0000);
        chk("t_wait_rdy",  {15'd0, in_ready},  16'h0001);
        in_valid = 1'b1;
        in_data  = 8'hAB;
        tick();
        chk("t_wren",      {15'd0, mem_wr_en}, 16'h0001);
        chk("t_addr",      mem_wr_addr,        16'h0100);
        chk("t_data",      mem_wr_data,        16'hABCD);
        chk("t_ready_wr",  {15'd0, in_ready},  16'h0000);
        in_valid = 1'b0;
        tick();
        chk("t_done",      {15'd0, done},      16'h0001);
        chk("t_wren_off",  {15'd0, mem_wr_en}, 16'h0000);
        tick();
        chk("t_idle",      {15'd0, busy},      16'h0000);

        // address wrap at the top of memory
        do_start(16'hFFFE, 16'd2);
        send_word(8'h01, 8'hA0);
        chk("w_addr1",     mem_wr_addr,        16'hFFFE);
        chk("w_data1",     mem_wr_data,        16'hA001);
        tick();
        send_word(8'h02, 8'hB0);
        chk("w_wren2",     {15'd0, mem_wr_en}, 16'h0001);
        chk("w_addr2",     mem_wr_addr,        16'h0000);
        chk("w_data2",     mem_wr_data,        16'hB002);
        tick();
        chk("w_done",      {15'd0, done},      16'h0001);
        tick();

        // zero word count goes straight to DONE
        do_start(16'h0040, 16'd0);
        chk("z_done",      {15'd0, done},      16'h0001);
        chk("z_busy",      {15'd0, busy},      16'h0001);
        chk("z_wren",      {15'd0, mem_wr_en}, 16'h0000);
        tick();
        chk("z_done_end",  {15'd0, done},      16'h0000);
        chk("z_idle",      {15'd0, busy},      16'h0000);
        chk("z_wren2",     {15'd0, mem_wr_en}, 16'h0000);

        // odd base address rejected
        do_start(16'h0003, 16'd1);
        chk("o_error",     {15'd0, error},     16'h0001);
        chk("o_busy",      {15'd0, busy},      16'h0000);
        chk("o_wren",      {15'd0, mem_wr_en}, 16'h0000);
        tick();
        chk("o_error_end", {15'd0, error},     16'h0000);
        chk("o_busy2",     {15'd0, busy},      16'h0000);

        // abort after the low byte of word 2 of 4
        do_start(16'h0200, 16'd4);
        send_word(8'h34, 8'h12);
        chk("a_wren1",     {15'd0, mem_wr_en}, 16'h0001);
        chk("a_data1",     mem_wr_data,        16'h1234);
        tick();
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_idle",      {15'd0, busy},      16'h0000);
        chk("a_ready",     {15'd0, in_ready},  16'h0000);
        chk("a_nodone",    {15'd0, done},      16'h0000);
        chk("a_nowren",    {15'd0, mem_wr_en}, 16'h0000);
        tick();
        chk("a_nodone2",   {15'd0, done},      16'h0000);
        chk("a_hold_addr", mem_wr_addr,        16'h0200);
        do_start(16'h0300, 16'd1);
        send_word(8'h9A, 8'hBC);
        chk("a_new_wren",  {15'd0, mem_wr_en}, 16'h0001);
        chk("a_new_addr",  mem_wr_addr,        16'h0300);
        chk("a_new_data",  mem_wr_data,        16'hBC9A);
        tick();
        chk("a_new_done",  {15'd0, done},      16'h0001);
        tick();

        // asynchronous reset while waiting for the high byte
        do_start(16'h0400, 16'd1);
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_data = 8'h22;
        #2;
        rst = 1'b0;
        #1;
        chk("r_busy",      {15'd0, busy},      16'h0000);
        chk("r_ready",     {15'd0, in_ready},  16'h0000);
        chk("r_wren",      {15'd0, mem_wr_en}, 16'h0000);
        chk("r_addr",      mem_wr_addr,        16'h0000);
        chk("r_data",      mem_wr_data,        16'h0000);
        chk("r_done",      {15'd0, done},      16'h0000);
        rst = 1'b1;
        tick();
        chk("r_post_wren1", {15'd0, mem_wr_en}, 16'h0000);
        tick();
        chk("r_post_wren2", {15'd0, mem_wr_en}, 16'h0000);
        chk("r_post_busy",  {15'd0, busy},      16'h0000);
        in_valid = 1'b0;
        tick();

        // start while busy is ignored
        do_start(16'h0500, 16'd1);
        start      = 1'b1;
        base_addr  = 16'h0600;
        word_count = 16'd3;
        tick();
        start = 1'b0;
        chk("s_busy",      {15'd0, busy},      16'h0001);
        chk("s_ready",     {15'd0, in_ready},  16'h0001);
        send_word(8'h01, 8'h02);
        chk("s_addr",      mem_wr_addr,        16'h0500);
        chk("s_data",      mem_wr_data,        16'h0201);
        tick();
        chk("s_done",      {15'd0, done},      16'h0001);
        tick();
        chk("s_idle",      {15'd0, busy},      16'h0000);

        // start together with abort in IDLE does nothing
        abort = 1'b1;
        do_start(16'h0700, 16'd1);
        abort = 1'b0;
        chk("sa_busy",     {15'd0, busy},      16'h0000);
        chk("sa_error",    {15'd0, error},     16'h0000);
        chk("sa_ready",    {15'd0, in_ready},  16'h0000);
        tick();
        chk("sa_busy2",    {15'd0, busy},      16'h0000);
        chk("sa_done",     {15'd0, done},      16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
